fp_addsub_pipe: RTL and testbench

FP_ADDSUB_PIPE -- requirements
Module: fp_addsub_pipe

---
 rtl/fp_addsub_pipe.sv | 197 +++++++++++++++++++
 tb/tb_fp_addsub_pipe.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_addsub_pipe.sv
// fp_addsub_pipe: four-stage floating-point add/subtract with DAZ/FTZ,
// round-to-nearest-even and a single global advance signal for all stages.
module fp_addsub_pipe #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
  input  logic                 op,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] result,
  output logic [2:0]           flags
);
  localparam int unsigned W    = 1 + EXP_W + MAN_W;
  localparam int unsigned FW   = MAN_W + 4;  // hidden + fraction + guard/round/sticky
  localparam int unsigned SW   = MAN_W + 5;  // FW plus carry-out
  localparam int unsigned LZW  = $clog2(SW);
  localparam int unsigned SPW  = W + 4;      // {is_special, value, flags}
  localparam int          EMAX = (1 << EXP_W) - 1;
  localparam logic [EXP_W-1:0] EONES = {EXP_W{1'b1}};
  localparam logic [MAN_W-1:0] FZERO = '0;
  localparam logic [W-1:0]     QNAN  = {1'b0, EONES, 1'b1, {(MAN_W-1){1'b0}}};

  logic adv;
  assign adv      = out_ready | ~out_valid;
  assign in_ready = adv;

  // ---------------- S1: unpack, classify, order by magnitude ----------------
  logic             sa, sb, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_snan, b_snan, swap;
  logic [EXP_W-1:0] ea, eb, e1_d, d1_d;
  logic [MAN_W-1:0] fa, fb;
  logic [W-2:0]     mag_a, mag_b;
  logic [MAN_W:0]   ma1_d, mb1_d;
  logic [SPW-1:0]   sp1_d;
  logic             s1_d;

  // Classify operands, pick the larger magnitude as A and resolve special cases early.
  always_comb begin
    sa     = a[W-1];
    sb     = b[W-1] ^ op;
    ea     = a[W-2:MAN_W];
    eb     = b[W-2:MAN_W];
    fa     = a[MAN_W-1:0];
    fb     = b[MAN_W-1:0];
    a_zero = (ea == '0);  // subnormals are treated as zero
    b_zero = (eb == '0);
    a_inf  = (ea == EONES) && (fa == '0);
    b_inf  = (eb == EONES) && (fb == '0);
    a_nan  = (ea == EONES) && (fa != '0);
    b_nan  = (eb == EONES) && (fb != '0);
    a_snan = a_nan && !fa[MAN_W-1];
    b_snan = b_nan && !fb[MAN_W-1];
    mag_a  = a_zero ? '0 : {ea, fa};
    mag_b  = b_zero ? '0 : {eb, fb};
    swap   = mag_b > mag_a;
    s1_d   = swap ? sb : sa;
    e1_d   = swap ? eb : ea;
    d1_d   = swap ? (eb - ea) : (ea - eb);
    ma1_d  = swap ? {~b_zero, b_zero ? FZERO : fb} : {~a_zero, a_zero ? FZERO : fa};
    mb1_d  = swap ? {~a_zero, a_zero ? FZERO : fa} : {~b_zero, b_zero ? FZERO : fb};
    sp1_d  = '0;
    if (a_nan || b_nan) begin
      sp1_d = {1'b1, QNAN, a_snan | b_snan, 2'b00};
    end else if (a_inf && b_inf) begin
      sp1_d = (sa != sb) ? {1'b1, QNAN, 3'b100} : {1'b1, sa, EONES, FZERO, 3'b000};
    end else if (a_inf) begin
      sp1_d = {1'b1, sa, EONES, FZERO, 3'b000};
    end else if (b_inf) begin
      sp1_d = {1'b1, sb, EONES, FZERO, 3'b000};
    end
  end

  logic             v1_q, s1_q, sub1_q, zs1_q;
  logic [SPW-1:0]   sp1_q;
  logic [EXP_W-1:0] e1_q, d1_q;
  logic [MAN_W:0]   ma1_q, mb1_q;

  // S1 register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q <= 1'b0; sp1_q <= '0; s1_q <= 1'b0; sub1_q <= 1'b0; zs1_q <= 1'b0;
      e1_q <= '0;   d1_q  <= '0; ma1_q <= '0;  mb1_q  <= '0;
    end else if (adv) begin
      v1_q <= in_valid; sp1_q <= sp1_d; s1_q <= s1_d; sub1_q <= sa ^ sb; zs1_q <= sa & sb;
      e1_q <= e1_d;     d1_q  <= d1_d;  ma1_q <= ma1_d; mb1_q <= mb1_d;
    end
  end

  // ---------------- S2: align B with guard/round/sticky ----------------
  logic [31:0]     sh;
  logic [2*FW-1:0] wide;
  logic [FW-1:0]   mb2_d;

  // Saturating right shift; everything pushed below the sticky position ORs into it.
  always_comb begin
    sh    = (32'(d1_q) > MAN_W + 3) ? MAN_W + 3 : 32'(d1_q);
    wide  = {mb1_q, 3'b000, {FW{1'b0}}} >> sh;
    mb2_d = {wide[2*FW-1:FW+1], wide[FW] | (|wide[FW-1:0])};
  end

  logic             v2_q, s2_q, sub2_q, zs2_q;
  logic [SPW-1:0]   sp2_q;
  logic [EXP_W-1:0] e2_q;
  logic [FW-1:0]    ma2_q, mb2_q;

  // S2 register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2_q <= 1'b0; sp2_q <= '0; s2_q <= 1'b0; sub2_q <= 1'b0; zs2_q <= 1'b0;
      e2_q <= '0;   ma2_q <= '0; mb2_q <= '0;
    end else if (adv) begin
      v2_q <= v1_q; sp2_q <= sp1_q; s2_q <= s1_q; sub2_q <= sub1_q; zs2_q <= zs1_q;
      e2_q <= e1_q; ma2_q <= {ma1_q, 3'b000}; mb2_q <= mb2_d;
    end
  end

  // ---------------- S3: magnitude add/subtract ----------------
  logic             v3_q, s3_q, zs3_q;
  logic [SPW-1:0]   sp3_q;
  logic [EXP_W-1:0] e3_q;
  logic [SW-1:0]    sum3_q;

  // S3 register; |A| >= |B| so the difference never goes negative.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v3_q <= 1'b0; sp3_q <= '0; s3_q <= 1'b0; zs3_q <= 1'b0; e3_q <= '0; sum3_q <= '0;
    end else if (adv) begin
      v3_q   <= v2_q; sp3_q <= sp2_q; s3_q <= s2_q; zs3_q <= zs2_q; e3_q <= e2_q;
      sum3_q <= sub2_q ? ({1'b0, ma2_q} - {1'b0, mb2_q}) : ({1'b0, ma2_q} + {1'b0, mb2_q});
    end
  end

  // ---------------- S4: normalize, round, pack ----------------
  logic [LZW-1:0]   lzc;
  logic [SW-1:0]    norm;
  logic             g, r, st;
  logic [MAN_W+1:0] mant_r;
  logic [MAN_W-1:0] frac;
  int               e_s;
  logic [W-1:0]     res_d;
  logic [2:0]       flg_d;

  // Single-pass leading-zero count, then RNE rounding and range checks.
  always_comb begin
    lzc = '0;
    for (int i = 0; i < int'(SW); i++) begin
      if (sum3_q[i]) lzc = LZW'(int'(SW) - 1 - i);
    end
    norm   = sum3_q << lzc;
    g      = norm[3];
    r      = norm[2];
    st     = |norm[1:0];
    mant_r = {1'b0, norm[SW-1:4]} + {{(MAN_W+1){1'b0}}, g & (r | st | norm[4])};
    frac   = mant_r[MAN_W+1] ? mant_r[MAN_W:1] : mant_r[MAN_W-1:0];
    e_s    = int'(e3_q) + 1 - int'(lzc) + int'(mant_r[MAN_W+1]);
    res_d  = '0;
    flg_d  = '0;
    if (sp3_q[SPW-1]) begin
      res_d = sp3_q[W+2:3];
      flg_d = sp3_q[2:0];
    end else if (sum3_q == '0) begin
      res_d = {zs3_q, {(W-1){1'b0}}};
    end else if (e_s <= 0) begin
      res_d = {s3_q, {(W-1){1'b0}}};
      flg_d = 3'b001;
    end else if (e_s >= EMAX) begin
      res_d = {s3_q, EONES, FZERO};
      flg_d = 3'b011;
    end else begin
      res_d = {s3_q, EXP_W'(e_s), frac};
      flg_d = {2'b00, g | r | st};
    end
  end

  logic             v4_q;
  logic [W-1:0]     res_q;
  logic [2:0]       flg_q;

  // Output register; holds while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v4_q <= 1'b0; res_q <= '0; flg_q <= '0;
    end else if (adv) begin
      v4_q <= v3_q; res_q <= res_d; flg_q <= flg_d;
    end
  end

  assign out_valid = v4_q;
  assign result    = res_q;
  assign flags     = flg_q;

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Bench for fp_addsub_pipe (binary32): directed vectors with hand-computed
// results, checked against a real-arithmetic reference model every output cycle.
module tb_fp_addsub_pipe;
  localparam int N = 20;
  localparam logic [31:0] VA [N] = '{
    32'h461C4000, 32'h411C0000, 32'h3F800000, 32'h7F800000, 32'h7F7FFFFF,
    32'h3F800000, 32'h80000000, 32'h80000000, 32'h7FA00000, 32'h7FC00000,
    32'hFF800000, 32'h3F800000, 32'h00400000, 32'h00C00000, 32'h3F800000,
    32'h3F800001, 32'h3F800001, 32'h40000000, 32'h4B000000, 32'h3F800000};
  localparam logic [31:0] VB [N] = '{
    32'h45FA0000, 32'h3F100000, 32'h33800000, 32'h7F800000, 32'h7F7FFFFF,
    32'h3F800000, 32'h80000000, 32'h00000000, 32'h3F800000, 32'h3F800000,
    32'h3F800000, 32'h7F800000, 32'h3F800000, 32'h00800000, 32'h34000000,
    32'h33800000, 32'h3F800000, 32'hC0400000, 32'h3F000000, 32'h2F800000};
  localparam bit VOP [N] = '{1, 0, 0, 1, 0, 1, 0, 1, 0, 0, 0, 1, 0, 1, 0, 0, 1, 0, 0, 0};
  localparam logic [31:0] VR [N] = '{
    32'h44FA0000, 32'h41250000, 32'h3F800000, 32'h7FC00000, 32'h7F800000,
    32'h00000000, 32'h80000000, 32'h80000000, 32'h7FC00000, 32'h7FC00000,
    32'hFF800000, 32'hFF800000, 32'h3F800000, 32'h00000000, 32'h3F800001,
    32'h3F800002, 32'h34000000, 32'hBF800000, 32'h4B000000, 32'h3F800000};
  localparam logic [2:0] VF [N] = '{
    3'b000, 3'b000, 3'b001, 3'b100, 3'b011, 3'b000, 3'b000, 3'b000, 3'b100, 3'b000,
    3'b000, 3'b000, 3'b000, 3'b001, 3'b000, 3'b001, 3'b000, 3'b000, 3'b001, 3'b001};

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, op, out_valid, out_ready;
  logic [31:0] a, b, result;
  logic [2:0]  flags;
  logic        lit_en;
  int          lit_id;
  int          errors = 0;
  int          checks = 0;

  typedef struct {
    logic [31:0] r;
    logic [2:0]  f;
    bit          lit;
    logic [31:0] lr;
    logic [2:0]  lf;
    int          id;
  } exp_t;
  exp_t q[$];

  fp_addsub_pipe #(.EXP_W(8), .MAN_W(23)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flags(flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  function automatic real f2r(input logic s, input logic [7:0] e, input logic [22:0] f);
    logic [10:0] de;
    de = {3'b000, e} + 11'd896;  // rebias 127 -> 1023
    return $bitstoreal({s, de, f, 29'h0});
  endfunction

  // Reference: exact sum in double precision (exact for these operands), then
  // round-to-nearest-even into binary32 with DAZ/FTZ and the special-value rules.
  function automatic logic [34:0] model(input logic [31:0] x, input logic [31:0] y, input bit o);
    logic        sx, sy, snx, sny, up, inx;
    logic [7:0]  ex, ey;
    logic [22:0] fx, fy;
    real         s;
    logic [63:0] d;
    int          e;
    logic [24:0] m;
    logic [28:0] rest;
    sx = x[31]; sy = y[31] ^ o;
    ex = x[30:23]; ey = y[30:23];
    fx = x[22:0];  fy = y[22:0];
    if ((ex == 8'hFF && fx != 0) || (ey == 8'hFF && fy != 0)) begin
      snx = (ex == 8'hFF) && (fx != 0) && !fx[22];
      sny = (ey == 8'hFF) && (fy != 0) && !fy[22];
      return {32'h7FC00000, snx | sny, 2'b00};
    end
    if (ex == 8'hFF && ey == 8'hFF)
      return (sx != sy) ? {32'h7FC00000, 3'b100} : {sx, 8'hFF, 23'h0, 3'b000};
    if (ex == 8'hFF) return {sx, 8'hFF, 23'h0, 3'b000};
    if (ey == 8'hFF) return {sy, 8'hFF, 23'h0, 3'b000};
    s = ((ex == 0) ? 0.0 : f2r(sx, ex, fx)) + ((ey == 0) ? 0.0 : f2r(sy, ey, fy));
    if (s == 0.0) return {sx & sy, 31'h0, 3'b000};
    d    = $realtobits(s);
    e    = int'(d[62:52]) - 1023 + 127;
    m    = {2'b01, d[51:29]};
    rest = d[28:0];
    inx  = (rest != 0);
    up   = (rest > 29'h10000000) || (rest == 29'h10000000 && m[0]);
    m    = m + 25'(up);
    if (m[24]) e = e + 1;
    if (e <= 0)   return {d[63], 31'h0, 3'b001};
    if (e >= 255) return {d[63], 8'hFF, 23'h0, 3'b011};
    return {d[63], 8'(e), m[22:0], 2'b00, inx};
  endfunction

  // Scoreboard: record accepted inputs, compare every valid output cycle.
  always @(negedge clk) begin
    exp_t        ex;
    logic [34:0] mv;
    if (!rst_n) begin
      q.delete();
    end else begin
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("spurious_out_valid", out_valid, 0);
        end else begin
          ex = q[0];
          chk($sformatf("result_v%0d", ex.id), result, ex.r);
          chk($sformatf("flags_v%0d", ex.id), flags, ex.f);
          if (ex.lit && out_ready) begin
            chk($sformatf("model_vs_literal_result_v%0d", ex.id), ex.r, ex.lr);
            chk($sformatf("model_vs_literal_flags_v%0d", ex.id), ex.f, ex.lf);
            chk($sformatf("dut_vs_literal_result_v%0d", ex.id), result, ex.lr);
            chk($sformatf("dut_vs_literal_flags_v%0d", ex.id), flags, ex.lf);
          end
          if (out_ready) void'(q.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        mv     = model(a, b, op);
        ex.r   = mv[34:3];
        ex.f   = mv[2:0];
        ex.lit = lit_en;
        ex.lr  = VR[lit_id];
        ex.lf  = VF[lit_id];
        ex.id  = lit_id;
        q.push_back(ex);
      end
    end
  end

  task automatic drive(input int i);
    a = VA[i]; b = VB[i]; op = VOP[i]; lit_id = i; lit_en = 1'b1; in_valid = 1'b1;
  endtask

  task automatic send_one(input int i, output int lat);
    out_ready = 1'b1;
    drive(i);
    @(posedge clk); #1;
    in_valid = 1'b0; lit_en = 1'b0; lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic stream(input int first, input int n, input bit stall, output int cycles);
    int idx;
    bit acc, saw_drop;
    idx = 0; cycles = 0; saw_drop = 1'b0;
    while (idx < n && cycles < 100) begin
      cycles++;
      out_ready = !(stall && cycles >= 5 && cycles <= 7);
      drive(first + idx);
      @(negedge clk);
      acc = in_ready;
      if (out_valid && !out_ready) begin
        chk("stall_in_ready_low", in_ready, 0);
        saw_drop = 1'b1;
      end
      @(posedge clk); #1;
      if (acc) idx++;
    end
    in_valid = 1'b0; lit_en = 1'b0; out_ready = 1'b1;
    chk("stream_accepted", idx, n);
    if (stall) chk("stall_observed", saw_drop, 1);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((q.size() != 0 || out_valid) && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    chk("drain_all_results_seen", q.size(), 0);
  endtask

  initial begin
    int lat, cyc, stale;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; op = 1'b0;
    lit_en = 1'b0; lit_id = 0;
    #2;
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_result", result, 0);
    chk("reset_flags", flags, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Isolated transactions: latency and value of each directed vector.
    for (int i = 0; i < N; i++) begin
      send_one(i, lat);
      chk($sformatf("latency_v%0d", i), lat, 4);
    end
    drain();

    // Back-to-back with consumer stall on edges 5-7.
    stream(0, 8, 1'b1, cyc);
    chk("stall_stream_cycles", cyc, 11);
    drain();

    // Full throughput with out_ready held high.
    stream(8, 8, 1'b0, cyc);
    chk("throughput_cycles", cyc, 8);
    drain();

    // Reset with transactions in flight.
    for (int i = 0; i < 4; i++) begin
      drive(i);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; lit_en = 1'b0;
    chk("pre_reset_out_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("midreset_out_valid", out_valid, 0);
    chk("midreset_in_ready", in_ready, 1);
    chk("midreset_result", result, 0);
    chk("midreset_flags", flags, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    stale = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    chk("no_stale_after_reset", stale, 0);
    @(posedge clk); #1;
    send_one(3, lat);
    chk("latency_after_reset", lat, 4);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    errors++;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
